mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor's data bus, downstream of the multi-cycle MIPS core, in parallel with the unified instruction/data memory.
- Snoops the core's adr/writedata/memwrite outputs and queues bytes written to its data register in a small FIFO.
- Serialises queued bytes onto txd as 8N1 frames.
- Provides a status word for the top level to mux onto the core's read-data path.

Parameters:
BASE_ADDR, 32'h0000_0100, word-aligned address of DATA register; STATUS at BASE_ADDR+4
CLKS_PER_BIT, 16, clock cycles per serial bit (min 2)
FIFO_DEPTH, 4, byte FIFO entries (power of 2, min 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-high reset
adr  input  32  core byte address
writedata  input  32  core store data; bits [7:0] used
memwrite  input  1  core store strobe, one cycle per store
sel  output  1  combinational: adr equals DATA or STATUS address
rdata  output  32  combinational status word, {28'b0, overflow, busy, full, empty}
txd  output  1  serial output, idle high
irq  output  1  high while FIFO empty and transmitter idle

Behaviour:
- Reset is checked at the clk edge and overrides everything. On reset: FIFO pointers and count = 0, overflow = 0, FSM = IDLE, baud counter = 0, txd = 1. Resulting outputs: empty = 1, busy = 0, full = 0, irq = 1.
- Reset during a frame aborts it; txd goes to 1 on that edge and the byte is lost.
- Address decode uses full 32-bit compare on adr; low two bits must be 00.
- DATA write: memwrite=1 and adr=BASE_ADDR pushes writedata[7:0] at that edge.
- If the FIFO is full, the byte is dropped and overflow is set (sticky).
- STATUS write: memwrite=1 and adr=BASE_ADDR+4 with writedata[3]=1 clears overflow.
- Other STATUS bits are read-only.
- rdata is valid whenever sel=1 and is purely combinational from registered state; no read side effects.
- FIFO: count width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH. full = (count==FIFO_DEPTH), empty = (count==0).
- Simultaneous push and pop in one cycle: both occur and count is unchanged. This holds when full, because the pop frees the slot in the same edge, so no overflow.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If FIFO non-empty: pop head into shift register, bit index = 0, baud counter = 0, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: txd = shift[0], LSB first. After CLKS_PER_BIT cycles, shift right and increment index. After index 7 completes, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then go to IDLE.
- busy = (state != IDLE).
- Pop happens on the IDLE→START edge. The first start-bit cycle is the cycle after a push into an empty FIFO, so push-to-start latency is 2 edges.
- Back-to-back bytes: IDLE lasts exactly 1 cycle between frames. Frame period = 10*CLKS_PER_BIT+1 cycles.
- txd is registered, with no combinational path from inputs.
- irq = empty & ~busy, registered as combinational logic of registered state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined: adds a PARITY state between DATA and STOP that drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame period becomes 11*CLKS_PER_BIT+1. rdata bit 4 reads 1, identifying a parity-capable build.
- When undefined: no PARITY state, 8N1 framing only, rdata bit 4 = 0.

Test Plan:
- Reset then idle → txd=1, rdata=32'h1 (via STATUS address), irq=1, sel=0 at adr=0.
- Store 32'h0000_00A5 to 0x100 (CLKS_PER_BIT=16) → start bit begins 2 edges later. txd bits 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. irq low during frame, high after stop.
- Five stores 0x41..0x45 in consecutive cycles with FIFO_DEPTH=4 → 0x41 popped immediately, 0x42–0x45 queued, full never causes drop, overflow=0. All 5 frames emitted, spaced 161 cycles apart.
- Six back-to-back stores with no drain → 6th dropped, rdata bit3=1. Store 32'h8 to 0x104 → bit3 clears. Only 5 bytes transmitted.
- Assert reset mid-DATA bit 3 of a frame → next edge txd=1, rdata=32'h1, queued bytes discarded, no further frames.
- With UART_TX_PARITY_EN, send 0x07 → parity bit 1 between bit7 and stop. rdata bit4=1, frame 177 cycles.

Source files
------------

// File: rtl/mmio_uart_tx_if.sv
// Core-side data bus snooped by the MMIO UART transmitter.
// master: core drives adr/writedata/memwrite; slave: UART returns sel/rdata.
interface mmio_uart_tx_if;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic        sel;
  logic [31:0] rdata;

  modport master (
    output adr, writedata, memwrite,
    input  sel, rdata
  );

  modport slave (
    input  adr, writedata, memwrite,
    output sel, rdata
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, snooping core stores.
// Ports: clk, reset (sync, high), bus (slave: adr/writedata/memwrite in,
// sel/rdata out), txd (serial, idle high), irq (FIFO empty and idle).
// Build option: define UART_TX_PARITY_EN for an even-parity bit (8E1).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           txd,
  output logic           irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_ID = 1'b1;
`else
  localparam logic PAR_ID = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic empty, full, busy, last;
  logic push_req, push_ok, pop, ovf_clr;
  logic unused_wdata;

  assign unused_wdata = ^bus.writedata[31:8];

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign busy  = (state_q != S_IDLE);
  assign last  = (cnt_q == BW'(CLKS_PER_BIT - 1));

  assign push_req = bus.memwrite && (bus.adr == BASE_ADDR);
  assign ovf_clr  = bus.memwrite && (bus.adr == STAT_ADDR)
                    && bus.writedata[3];
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign push_ok  = push_req && (!full || pop);

  assign bus.sel   = (bus.adr == BASE_ADDR) || (bus.adr == STAT_ADDR);
  assign bus.rdata = {27'b0, PAR_ID, ovf_q, busy, full, empty};
  assign txd       = txd_q;
  assign irq       = empty && !busy;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (pop)     rptr_d = rptr_q + PW'(1);
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) ovf_d = 1'b1;
    else if (ovf_clr)         ovf_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
          par_d   = ^mem_q[rptr_q];
`endif
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (last) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      S_DATA: begin
        if (last) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (last) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // txd is registered from the next state so it has no input path.
    unique case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= bus.writedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed stores, scoreboard of expected bytes,
// serial frame monitor checking every txd cycle and frame spacing.
module tb_mmio_uart_tx;

  localparam int C = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] EXP_ID = 32'h11;
`else
  localparam int NB = 10;
  localparam logic [31:0] EXP_ID = 32'h1;
`endif
  localparam int PERIOD = NB * C + 1;
  localparam logic [31:0] DATA_A = 32'h100;
  localparam logic [31:0] STAT_A = 32'h104;

  logic clk = 1'b0;
  logic reset;
  logic txd, irq;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR    (DATA_A),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .txd   (txd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] exp_q [$];
  int         starts [$];

  bit         mon_active = 0;
  int         mon_cnt = 0;
  int         rx_cnt = 0;
  logic [10:0] frm;
  logic [7:0] rx_b, exp_b;
  logic       frm_bad;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] build(logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 0;
    end else begin
      if (!mon_active && txd === 1'b0) begin
        mon_active = 1;
        mon_cnt    = 0;
        frm_bad    = 1'b0;
        rx_b       = '0;
        starts.push_back(cyc);
        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        frm   = build(exp_b);
      end
      if (mon_active) begin
        if (txd !== frm[mon_cnt / C]) frm_bad = 1'b1;
        if (mon_cnt % C == C / 2 && mon_cnt / C >= 1
            && mon_cnt / C <= 8)
          rx_b[mon_cnt / C - 1] = txd;
        mon_cnt++;
        if (mon_cnt == NB * C) begin
          check("rx_byte", 32'(rx_b), 32'(exp_b));
          check("frame_shape", 32'(frm_bad), 32'd0);
          rx_cnt++;
          mon_active = 0;
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d, bit acc);
    bus.adr       = a;
    bus.writedata = d;
    bus.memwrite  = 1'b1;
    if (acc) exp_q.push_back(d[7:0]);
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
    bus.adr      = STAT_A;
  endtask

  task automatic wait_frames(int target);
    int budget;
    budget = 3 * PERIOD * 6;
    while (rx_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("frame_timeout", 32'(rx_cnt >= target), 32'd1);
  endtask

  initial begin
    int base;
    int tgt;
    int bad;
    reset         = 1'b1;
    bus.adr       = '0;
    bus.writedata = '0;
    bus.memwrite  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_irq", 32'(irq), 32'd1);
    check("sel_adr0", 32'(bus.sel), 32'd0);
    bus.adr = STAT_A;
    #1;
    check("sel_stat", 32'(bus.sel), 32'd1);
    check("rst_rdata", bus.rdata, EXP_ID);
    bus.adr = 32'h101;
    #1;
    check("sel_unaligned", 32'(bus.sel), 32'd0);
    bus.adr = DATA_A;
    #1;
    check("sel_data", 32'(bus.sel), 32'd1);

    // single byte, start latency and irq
    sync();
    store(DATA_A, 32'h0000_00A5, 1);
    @(negedge clk);
    check("lat_txd_idle", 32'(txd), 32'd1);
    check("lat_irq_low", 32'(irq), 32'd0);
    check("lat_nonempty", 32'(bus.rdata[0]), 32'd0);
    @(negedge clk);
    check("lat_start", 32'(txd), 32'd0);
    check("lat_busy", 32'(bus.rdata[2]), 32'd1);
    wait_frames(1);
    @(negedge clk);
    check("post_irq", 32'(irq), 32'd1);
    check("post_rdata", bus.rdata, EXP_ID);

    // five consecutive stores: fill without drop, spacing
    base = starts.size();
    sync();
    for (int i = 0; i < 5; i++) store(DATA_A, 32'h41 + i, 1);
    check("burst_status", 32'(bus.rdata[3:0]), 32'h6);
    wait_frames(6);
    for (int k = 0; k < 4; k++)
      check("spacing", 32'(starts[base + k + 1] - starts[base + k]),
            32'(PERIOD));
    @(negedge clk);
    check("burst_ovf", 32'(bus.rdata[3]), 32'd0);

    // overflow: sixth store dropped, then cleared
    sync();
    for (int i = 0; i < 5; i++) store(DATA_A, 32'h51 + i, 1);
    store(DATA_A, 32'h56, 0);
    check("ovf_set", 32'(bus.rdata[3]), 32'd1);
    store(STAT_A, 32'h4, 0);
    check("ovf_hold", 32'(bus.rdata[3]), 32'd1);
    store(STAT_A, 32'h8, 0);
    check("ovf_clr", 32'(bus.rdata[3]), 32'd0);
    wait_frames(11);
    repeat (2 * PERIOD) @(negedge clk);
    check("ovf_count", 32'(rx_cnt), 32'd11);

    // reset in the middle of data bit 3
    sync();
    store(DATA_A, 32'h33, 1);
    store(DATA_A, 32'h34, 1);
    store(DATA_A, 32'h35, 1);
    tgt = 4 * PERIOD;
    while (!mon_active && tgt > 0) begin
      @(negedge clk);
      tgt--;
    end
    check("mid_start_seen", 32'(mon_active), 32'd1);
    repeat (4 * C + C / 2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_rdata", bus.rdata, EXP_ID);
    check("mid_rst_irq", 32'(irq), 32'd1);
    bad = 0;
    repeat (3 * PERIOD) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    check("mid_rst_quiet", 32'(bad), 32'd0);
    check("mid_rst_count", 32'(rx_cnt), 32'd11);

`ifdef UART_TX_PARITY_EN
    sync();
    store(DATA_A, 32'h07, 1);
    wait_frames(12);
    check("par_id", 32'(bus.rdata[4]), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
